fir_seq_controller: RTL and testbench
=====================================

FIR_SEQ_CONTROLLER -- requirements
Module: fir_seq_controller

Interface
REQ-001 SHALL provide parameter NUM_RJ, default 16: Rj table entries loaded per configuration.
REQ-002 SHALL provide parameter NUM_COEFF, default 512: coefficient entries loaded per configuration.
REQ-003 SHALL provide parameter DATA_DEPTH, default 256: input buffer entries; data address wraps modulo this.
REQ-004 SHALL provide parameter NUM_CH, default 2: number of channels with zero detectors.
REQ-005 SHALL provide parameter SLEEP_RUN, default 800: consecutive all-zero samples before sleep.
REQ-006 Sclk  in  1  single clock; all state changes on its rising edge.
REQ-007 Reset_n  in  1  asynchronous, active-low reset.
REQ-008 Start  in  1  synchronous enable; low forces IDLE.
REQ-009 Frame  in  1  frame marker; sampled only in WAIT_RJ, WAIT_COEFF and WAIT_INPUT.
REQ-010 input_ready  in  1  word-available level from the Dclk domain; asynchronous to Sclk.
REQ-011 allzeros  in  NUM_CH  per-channel all-zero flags.
REQ-012 rj_addr, coeff_addr, data_addr  out  clog2(NUM_RJ), clog2(NUM_COEFF), clog2(DATA_DEPTH)  write addresses.
REQ-013 rj_we, coeff_we, data_we  out  1 each  single-cycle write strobes.
REQ-014 en_FIR, sleep_flag, InReady, Clear  out  1 each  FIR step, sleep indication, ready to accept input, datapath clear.

Function
REQ-015 States SHALL be IDLE, WAIT_RJ, LOAD_RJ, WAIT_COEFF, LOAD_COEFF, WAIT_INPUT, WORK and SLEEP.
REQ-016 input_ready SHALL pass through a two-flop synchroniser and rising-edge detector; a "ready event" is one Sclk-cycle pulse three cycles after the input_ready rise.
REQ-017 IDLE: Clear=1, InReady=0; Start=1 SHALL go to WAIT_RJ next cycle.
REQ-018 WAIT_RJ/WAIT_COEFF/WAIT_INPUT: Frame=1 SHALL go to LOAD_RJ/LOAD_COEFF/WORK respectively.
REQ-019 LOAD_RJ: each ready event SHALL pulse rj_we for one cycle with rj_addr = event index (0..NUM_RJ-1); the NUM_RJ-th event SHALL go to WAIT_COEFF. LOAD_COEFF SHALL behave identically with NUM_COEFF, then go to WAIT_INPUT.
REQ-020 WORK: each ready event SHALL pulse data_we and en_FIR in the same cycle; data_addr SHALL increment, wrapping DATA_DEPTH-1 -> 0.
REQ-021 A zero-run counter SHALL increment on each WORK ready event with all allzeros bits high and clear on any event with a low bit; the event making it equal SLEEP_RUN SHALL still strobe and SHALL go to SLEEP.
REQ-022 SLEEP: sleep_flag=1, no strobes on all-zero events; the first event with any allzeros bit low SHALL strobe data_we and en_FIR in that cycle, clear the run counter and go to WORK.
REQ-023 InReady SHALL be 1 in every state except IDLE; strobes SHALL never assert outside LOAD_RJ, LOAD_COEFF, WORK and SLEEP.
REQ-024 Start=0 SHALL override all: IDLE next cycle, counters zeroed, a coincident ready event discarded.
REQ-025 Ready events arriving in any WAIT_* state SHALL be ignored and not counted.

Reset
REQ-026 Reset_n low SHALL immediately force IDLE, all counters and addresses to 0, all strobes, en_FIR and sleep_flag to 0, Clear=1, InReady=0.
REQ-027 Reset mid-load or mid-WORK SHALL require a full Rj and coefficient reload after Start.

Configuration
REQ-028 With FIR_CTRL_SLEEP_EN defined, SLEEP and the zero-run counter SHALL exist; without it, WORK SHALL never leave on zeros, sleep_flag SHALL be tied 0 and allzeros ignored.

Structure
REQ-029 Package fir_ctrl_pkg SHALL hold the state enumeration and default parameter constants.
REQ-030 Synchroniser plus edge detector SHALL be sub-module ready_edge_sync.

Verification
REQ-031 Reset, Start=1, Frame, 16 ready pulses -> rj_addr 0..15 with 16 rj_we pulses, then WAIT_COEFF.
REQ-032 512 coefficient pulses -> coeff_addr 0..511, WAIT_INPUT; Frame -> WORK; 300 pulses -> data_addr wraps 255 -> 0 at event 257.
REQ-033 SLEEP_RUN=4, allzeros=2'b11 -> 4 strobes then sleep_flag=1; allzeros=2'b01 on next event -> data_we+en_FIR same cycle, WORK.
REQ-034 Start=0 coincident with a ready event in LOAD_COEFF at addr 100 -> no coeff_we, IDLE next cycle, Clear=1.
REQ-035 Reset_n low mid-WORK -> outputs at reset values asynchronously; after Start, Rj reload required from rj_addr 0.
REQ-036 Build without FIR_CTRL_SLEEP_EN, 1000 all-zero events -> stays WORK, sleep_flag=0, 1000 strobes.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared state encoding, default sizing constants and an address-width helper
// for the FIR sequencing controller.
package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RJ,
        LOAD_RJ,
        WAIT_COEFF,
        LOAD_COEFF,
        WAIT_INPUT,
        WORK,
        SLEEP
    } ctrl_state_t;

    localparam int DEF_NUM_RJ     = 16;
    localparam int DEF_NUM_COEFF  = 512;
    localparam int DEF_DATA_DEPTH = 256;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_SLEEP_RUN  = 800;

    // Address width for a table of n entries; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ready_edge_sync.sv
// Brings the Dclk-domain input_ready level into Sclk and emits a one-cycle
// ready event, registered, three Sclk cycles after the level rises.
module ready_edge_sync (
    input  logic Sclk,
    input  logic Reset_n,
    input  logic async_in,
    output logic ready_evt
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;
    logic evt_reg;

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
            evt_reg  <= 1'b0;
        end else begin
            meta_reg <= async_in;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
            evt_reg  <= sync_reg & ~prev_reg;
        end
    end

    assign ready_evt = evt_reg;

endmodule

// File: rtl/fir_seq_controller.sv
// Sequencer for Rj/coefficient loading, input capture and FIR stepping.
// Optional zero-run sleep is built only when FIR_CTRL_SLEEP_EN is defined.
module fir_seq_controller
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_RJ     = DEF_NUM_RJ,
    parameter int NUM_COEFF  = DEF_NUM_COEFF,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int SLEEP_RUN  = DEF_SLEEP_RUN
) (
    input  logic                             Sclk,
    input  logic                             Reset_n,
    input  logic                             Start,
    input  logic                             Frame,
    input  logic                             input_ready,
    input  logic [NUM_CH-1:0]                allzeros,
    output logic [addr_w(NUM_RJ)-1:0]        rj_addr,
    output logic [addr_w(NUM_COEFF)-1:0]     coeff_addr,
    output logic [addr_w(DATA_DEPTH)-1:0]    data_addr,
    output logic                             rj_we,
    output logic                             coeff_we,
    output logic                             data_we,
    output logic                             en_FIR,
    output logic                             sleep_flag,
    output logic                             InReady,
    output logic                             Clear
);

    localparam int RJ_W = addr_w(NUM_RJ);
    localparam int CO_W = addr_w(NUM_COEFF);
    localparam int DA_W = addr_w(DATA_DEPTH);

    ctrl_state_t     state_reg, state_next;
    logic [RJ_W-1:0] rj_cnt_reg, rj_cnt_next;
    logic [CO_W-1:0] coeff_cnt_reg, coeff_cnt_next;
    logic [DA_W-1:0] data_cnt_reg, data_cnt_next;
    logic            ready_evt;
    logic            rj_we_c, coeff_we_c, data_we_c;
    logic [DA_W-1:0] data_cnt_inc;

    ready_edge_sync u_ready_sync (
        .Sclk      (Sclk),
        .Reset_n   (Reset_n),
        .async_in  (input_ready),
        .ready_evt (ready_evt)
    );

    assign data_cnt_inc = (data_cnt_reg == DA_W'(DATA_DEPTH - 1)) ? '0 : data_cnt_reg + 1'b1;

`ifdef FIR_CTRL_SLEEP_EN
    localparam int RUN_W = addr_w(SLEEP_RUN + 1);

    logic [RUN_W-1:0] run_cnt_reg, run_cnt_next;
    logic             all_zero;

    assign all_zero = &allzeros;

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            run_cnt_reg <= '0;
        end else begin
            run_cnt_reg <= run_cnt_next;
        end
    end
`else
    logic unused_allzeros;
    assign unused_allzeros = &{1'b0, allzeros};
`endif

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg     <= IDLE;
            rj_cnt_reg    <= '0;
            coeff_cnt_reg <= '0;
            data_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            rj_cnt_reg    <= rj_cnt_next;
            coeff_cnt_reg <= coeff_cnt_next;
            data_cnt_reg  <= data_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rj_cnt_next    = rj_cnt_reg;
        coeff_cnt_next = coeff_cnt_reg;
        data_cnt_next  = data_cnt_reg;
        rj_we_c        = 1'b0;
        coeff_we_c     = 1'b0;
        data_we_c      = 1'b0;
`ifdef FIR_CTRL_SLEEP_EN
        run_cnt_next   = run_cnt_reg;
`endif

        // Dropping Start abandons everything, including an event in flight.
        if (!Start) begin
            state_next     = IDLE;
            rj_cnt_next    = '0;
            coeff_cnt_next = '0;
            data_cnt_next  = '0;
`ifdef FIR_CTRL_SLEEP_EN
            run_cnt_next   = '0;
`endif
        end else begin
            case (state_reg)
                IDLE: state_next = WAIT_RJ;

                WAIT_RJ: if (Frame) state_next = LOAD_RJ;

                LOAD_RJ: begin
                    if (ready_evt) begin
                        rj_we_c = 1'b1;
                        if (rj_cnt_reg == RJ_W'(NUM_RJ - 1)) begin
                            rj_cnt_next = '0;
                            state_next  = WAIT_COEFF;
                        end else begin
                            rj_cnt_next = rj_cnt_reg + 1'b1;
                        end
                    end
                end

                WAIT_COEFF: if (Frame) state_next = LOAD_COEFF;

                LOAD_COEFF: begin
                    if (ready_evt) begin
                        coeff_we_c = 1'b1;
                        if (coeff_cnt_reg == CO_W'(NUM_COEFF - 1)) begin
                            coeff_cnt_next = '0;
                            state_next     = WAIT_INPUT;
                        end else begin
                            coeff_cnt_next = coeff_cnt_reg + 1'b1;
                        end
                    end
                end

                WAIT_INPUT: if (Frame) state_next = WORK;

                WORK: begin
                    if (ready_evt) begin
                        data_we_c     = 1'b1;
                        data_cnt_next = data_cnt_inc;
`ifdef FIR_CTRL_SLEEP_EN
                        if (all_zero) begin
                            if (run_cnt_reg == RUN_W'(SLEEP_RUN - 1)) begin
                                run_cnt_next = RUN_W'(SLEEP_RUN);
                                state_next   = SLEEP;
                            end else begin
                                run_cnt_next = run_cnt_reg + 1'b1;
                            end
                        end else begin
                            run_cnt_next = '0;
                        end
`endif
                    end
                end

                SLEEP: begin
`ifdef FIR_CTRL_SLEEP_EN
                    // Only a non-silent sample wakes the filter; it is written immediately.
                    if (ready_evt && !all_zero) begin
                        data_we_c     = 1'b1;
                        data_cnt_next = data_cnt_inc;
                        run_cnt_next  = '0;
                        state_next    = WORK;
                    end
`else
                    state_next = IDLE;
`endif
                end

                default: state_next = IDLE;
            endcase
        end
    end

    assign rj_addr    = rj_cnt_reg;
    assign coeff_addr = coeff_cnt_reg;
    assign data_addr  = data_cnt_reg;
    assign rj_we      = rj_we_c;
    assign coeff_we   = coeff_we_c;
    assign data_we    = data_we_c;
    assign en_FIR     = data_we_c;
    assign Clear      = (state_reg == IDLE);
    assign InReady    = (state_reg != IDLE);
`ifdef FIR_CTRL_SLEEP_EN
    assign sleep_flag = (state_reg == SLEEP);
`else
    assign sleep_flag = 1'b0;
`endif

endmodule

// File: tb/tb_fir_seq_controller.sv
// Directed bench for fir_seq_controller: load sequence, WORK wrap, sleep or
// no-sleep zero runs, Start abort and asynchronous reset.
module tb_fir_seq_controller;
    import fir_ctrl_pkg::*;

    logic        Sclk = 1'b0;
    logic        Reset_n, Start, Frame, input_ready;
    logic [1:0]  allzeros;
    logic [3:0]  rj_addr;
    logic [8:0]  coeff_addr;
    logic [7:0]  data_addr;
    logic        rj_we, coeff_we, data_we, en_FIR, sleep_flag, InReady, Clear;

    int total = 0;
    int bad   = 0;
    int n_rj, n_co, n_da, n_en, n_mis, n_slp, evt_no;
    int a_rj, a_co, a_da, a_co_k3;
    int exp_d, sum_da, sum_slp;

    fir_seq_controller #(
        .NUM_RJ(16), .NUM_COEFF(512), .DATA_DEPTH(256), .NUM_CH(2), .SLEEP_RUN(4)
    ) dut (
        .Sclk(Sclk), .Reset_n(Reset_n), .Start(Start), .Frame(Frame),
        .input_ready(input_ready), .allzeros(allzeros),
        .rj_addr(rj_addr), .coeff_addr(coeff_addr), .data_addr(data_addr),
        .rj_we(rj_we), .coeff_we(coeff_we), .data_we(data_we), .en_FIR(en_FIR),
        .sleep_flag(sleep_flag), .InReady(InReady), .Clear(Clear)
    );

    always #5 Sclk = ~Sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One input_ready pulse; strobes and addresses are tallied over the 7 cycles it spans.
    task automatic fire(input logic drop_start);
        n_rj = 0; n_co = 0; n_da = 0; n_en = 0; n_mis = 0; n_slp = 0;
        a_rj = -1; a_co = -1; a_da = -1; a_co_k3 = -1;
        @(negedge Sclk);
        input_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge Sclk);
            if (k == 4) input_ready = 1'b0;
            if (k == 3 && drop_start) Start = 1'b0;
            #1;
            if (k == 3) a_co_k3 = int'(coeff_addr);
            if (rj_we)    begin n_rj++; a_rj = int'(rj_addr);    end
            if (coeff_we) begin n_co++; a_co = int'(coeff_addr); end
            if (data_we)  begin n_da++; a_da = int'(data_addr);  end
            if (en_FIR)   n_en++;
            if (data_we !== en_FIR) n_mis++;
            if (sleep_flag) n_slp++;
        end
        evt_no++;
        $display("evt %0d: rj_we=%0d@%0d coeff_we=%0d@%0d data_we=%0d@%0d en_FIR=%0d sleep=%0d",
                 evt_no, n_rj, a_rj, n_co, a_co, n_da, a_da, n_en, n_slp);
    endtask

    task automatic frame_pulse();
        @(negedge Sclk);
        Frame = 1'b1;
        @(negedge Sclk);
        Frame = 1'b0;
        #1;
    endtask

    initial begin
        evt_no = 0;
        Reset_n = 1'b0; Start = 1'b0; Frame = 1'b0; input_ready = 1'b0; allzeros = 2'b00;
        #3;
        chk("rst_clear", 32'(Clear), 1);
        chk("rst_inready", 32'(InReady), 0);
        chk("rst_rj_addr", 32'(rj_addr), 0);
        chk("rst_strobes", 32'({rj_we, coeff_we, data_we, en_FIR}), 0);
        chk("rst_sleep", 32'(sleep_flag), 0);

        repeat (3) @(negedge Sclk);
        Reset_n = 1'b1;
        @(negedge Sclk);
        Start = 1'b1;
        @(negedge Sclk);
        #1;
        chk("start_state", 32'(dut.state_reg), 32'(WAIT_RJ));
        chk("start_inready", 32'(InReady), 1);
        chk("start_clear", 32'(Clear), 0);

        fire(1'b0);
        chk("wait_rj_ignored", 32'(n_rj), 0);
        chk("wait_rj_addr", 32'(rj_addr), 0);

        frame_pulse();
        chk("load_rj_state", 32'(dut.state_reg), 32'(LOAD_RJ));
        for (int i = 0; i < 16; i++) begin
            fire(1'b0);
            chk("rj_we_count", 32'(n_rj), 1);
            chk("rj_addr", 32'(a_rj), 32'(i));
        end
        chk("after_rj_state", 32'(dut.state_reg), 32'(WAIT_COEFF));
        fire(1'b0);
        chk("wait_coeff_ignored", 32'(n_co + n_rj), 0);

        frame_pulse();
        for (int i = 0; i < 512; i++) begin
            fire(1'b0);
            chk("coeff_we_count", 32'(n_co), 1);
            chk("coeff_addr", 32'(a_co), 32'(i));
        end
        chk("after_coeff_state", 32'(dut.state_reg), 32'(WAIT_INPUT));
        fire(1'b0);
        chk("wait_input_ignored", 32'(n_da), 0);

        frame_pulse();
        chk("work_state", 32'(dut.state_reg), 32'(WORK));
        exp_d = 0;
        for (int i = 0; i < 300; i++) begin
            fire(1'b0);
            chk("data_we_count", 32'(n_da), 1);
            chk("en_fir_with_we", 32'(n_mis), 0);
            chk("data_addr", 32'(a_da), 32'(exp_d));
            if (i == 256) chk("data_addr_wrap", 32'(a_da), 0);
            exp_d = (exp_d + 1) % 256;
        end

`ifdef FIR_CTRL_SLEEP_EN
        allzeros = 2'b11;
        for (int i = 0; i < 4; i++) begin
            fire(1'b0);
            chk("zero_strobe", 32'(n_da), 1);
            chk("zero_addr", 32'(a_da), 32'(exp_d));
            exp_d = (exp_d + 1) % 256;
        end
        chk("sleep_state", 32'(dut.state_reg), 32'(SLEEP));
        chk("sleep_flag_on", 32'(sleep_flag), 1);
        fire(1'b0);
        chk("sleep_no_strobe", 32'(n_da + n_en), 0);
        allzeros = 2'b01;
        fire(1'b0);
        chk("wake_data_we", 32'(n_da), 1);
        chk("wake_en_fir", 32'(n_en), 1);
        chk("wake_same_cycle", 32'(n_mis), 0);
        chk("wake_addr", 32'(a_da), 32'(exp_d));
        chk("wake_state", 32'(dut.state_reg), 32'(WORK));
        chk("wake_sleep_flag", 32'(sleep_flag), 0);
`else
        allzeros = 2'b11;
        sum_da = 0; sum_slp = 0;
        for (int i = 0; i < 1000; i++) begin
            fire(1'b0);
            sum_da += n_da;
            sum_slp += n_slp;
        end
        chk("nosleep_strobes", 32'(sum_da), 1000);
        chk("nosleep_flag", 32'(sum_slp), 0);
        chk("nosleep_state", 32'(dut.state_reg), 32'(WORK));
`endif

        // Asynchronous reset in the middle of a clock phase.
        @(posedge Sclk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_state", 32'(dut.state_reg), 32'(IDLE));
        chk("async_clear", 32'(Clear), 1);
        chk("async_inready", 32'(InReady), 0);
        chk("async_data_addr", 32'(data_addr), 0);
        chk("async_strobes", 32'({data_we, en_FIR, sleep_flag}), 0);
        @(negedge Sclk);
        Reset_n = 1'b1;
        @(negedge Sclk);
        #1;
        chk("rerun_state", 32'(dut.state_reg), 32'(WAIT_RJ));
        fire(1'b0);
        chk("rerun_wait_ignored", 32'(n_rj + n_da), 0);
        frame_pulse();
        fire(1'b0);
        chk("reload_rj_we", 32'(n_rj), 1);
        chk("reload_rj_addr0", 32'(a_rj), 0);
        for (int i = 1; i < 16; i++) fire(1'b0);
        chk("reload_state", 32'(dut.state_reg), 32'(WAIT_COEFF));

        // Start dropped on the very cycle of a coefficient event.
        frame_pulse();
        for (int i = 0; i < 100; i++) fire(1'b0);
        fire(1'b1);
        chk("abort_addr", 32'(a_co_k3), 100);
        chk("abort_no_coeff_we", 32'(n_co), 0);
        chk("abort_state", 32'(dut.state_reg), 32'(IDLE));
        chk("abort_clear", 32'(Clear), 1);
        chk("abort_coeff_addr", 32'(coeff_addr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
